// File: rtl/icache_refill_if.sv
// Line-wide memory port between the icache refill engine and the memory system.
// paddr carries a 32-bit word address; data returns a whole cache line.
interface icache_refill_if #(
  parameter int unsigned PADDR_W = 56,
  parameter int unsigned LINE_W  = 128
);
  logic               req;
  logic [PADDR_W-1:0] paddr;
  logic               ready;
  logic [LINE_W-1:0]  data;

  modport master (output req, paddr, input ready, data);
  modport slave  (input req, paddr, output ready, data);
endinterface

// File: rtl/icache_refill.sv
// Icache miss/refill engine: one miss at a time, line fetch, array fill, response
// to fetch, plus whole-cache invalidation after reset and on flush_i.
module icache_refill #(
  parameter int unsigned NUM_SETS          = 256,
  parameter int unsigned NUM_WAYS          = 4,
  parameter int unsigned PADDR_W           = 56,
  parameter int unsigned ICACHE_LINE_WIDTH = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          miss_valid_i,
  output logic                          miss_ready_o,
  input  logic [PADDR_W-1:0]            miss_paddr_i,
  input  logic [$clog2(NUM_WAYS)-1:0]   miss_way_i,
  input  logic                          kill_i,
  input  logic                          flush_i,
  output logic                          busy_o,
  icache_refill_if.master               mreq,
  output logic                          wr_en_o,
  output logic [$clog2(NUM_SETS)-1:0]   wr_set_o,
  output logic [NUM_WAYS-1:0]           wr_way_o,
  output logic [PADDR_W-$clog2(NUM_SETS)-$clog2(ICACHE_LINE_WIDTH/8)-1:0] wr_tag_o,
  output logic                          wr_valid_o,
  output logic [ICACHE_LINE_WIDTH-1:0]  wr_data_o,
  output logic                          rsp_valid_o,
  output logic [PADDR_W-1:0]            rsp_paddr_o,
  output logic [ICACHE_LINE_WIDTH-1:0]  rsp_data_o
);
  localparam int unsigned OFF_W = $clog2(ICACHE_LINE_WIDTH/8);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = PADDR_W - IDX_W - OFF_W;
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_MEM, S_FILL, S_RESP} state_t;

  state_t                       r_state, w_next;
  logic [IDX_W-1:0]             r_cnt;
  logic [PADDR_W-1:0]           r_addr;
  logic [WAY_W-1:0]             r_way;
  logic [ICACHE_LINE_WIDTH-1:0] r_line;
  logic                         r_killed;
  logic                         r_flush_pend;
  logic                         w_accept;
  logic                         w_flush_go;

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_flush_go   = 1'b0;
    miss_ready_o = 1'b0;
    mreq.req     = 1'b0;
    wr_en_o      = 1'b0;
    wr_set_o     = r_cnt;
    wr_way_o     = '1;
    wr_valid_o   = 1'b0;
    rsp_valid_o  = 1'b0;
    unique case (r_state)
      S_FLUSH: begin
        // Reset state is FLUSH; hold the strobe off while reset is still asserted.
        wr_en_o = !rst_i;
        if (r_cnt == IDX_W'(NUM_SETS - 1)) w_next = S_IDLE;
      end
      S_IDLE: begin
        miss_ready_o = !flush_i && !r_flush_pend;
        if (flush_i || r_flush_pend) begin
          w_flush_go = 1'b1;
          w_next     = S_FLUSH;
        end else if (miss_valid_i) begin
          w_accept = 1'b1;
          w_next   = S_MEM;
        end
      end
      S_MEM: begin
        mreq.req = 1'b1;
        if (mreq.ready) w_next = S_FILL;
      end
      S_FILL: begin
        wr_en_o    = 1'b1;
        wr_valid_o = 1'b1;
        wr_way_o   = NUM_WAYS'(1) << r_way;
        wr_set_o   = r_addr[OFF_W +: IDX_W];
        w_next     = (r_killed || kill_i) ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = !kill_i;
        w_next      = S_IDLE;
      end
      default: w_next = S_FLUSH;
    endcase
  end

  assign mreq.paddr  = r_addr >> 2;
  assign wr_tag_o    = r_addr[PADDR_W-1 -: TAG_W];
  assign wr_data_o   = r_line;
  assign rsp_paddr_o = r_addr;
  assign rsp_data_o  = r_line;
  assign busy_o      = (r_state != S_IDLE) || r_flush_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_FLUSH;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_way        <= '0;
      r_line       <= '0;
      r_killed     <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FLUSH)  r_cnt <= r_cnt + 1'b1;
      else if (w_flush_go)     r_cnt <= '0;
      if (w_accept) begin
        r_addr   <= miss_paddr_i & ~PADDR_W'(ICACHE_LINE_WIDTH/8 - 1);
        r_way    <= miss_way_i;
        r_killed <= 1'b0;
      end else if ((r_state == S_MEM || r_state == S_FILL) && kill_i) begin
        r_killed <= 1'b1;
      end
      if (r_state == S_MEM && mreq.ready) r_line <= mreq.data;
      // A flush requested mid-refill waits for the refill to finish.
      if (r_state == S_FLUSH && w_next == S_IDLE)
        r_flush_pend <= 1'b0;
      else if ((r_state inside {S_MEM, S_FILL, S_RESP}) && flush_i)
        r_flush_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: a transaction-level model predicts every
// array write, response, memory request window and busy window by cycle number.
module tb_icache_refill;
  logic         clk = 1'b0;
  logic         rst_i;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [55:0]  miss_paddr_i;
  logic [1:0]   miss_way_i;
  logic         kill_i;
  logic         flush_i;
  logic         busy_o;
  logic         wr_en_o;
  logic [7:0]   wr_set_o;
  logic [3:0]   wr_way_o;
  logic [43:0]  wr_tag_o;
  logic         wr_valid_o;
  logic [127:0] wr_data_o;
  logic         rsp_valid_o;
  logic [55:0]  rsp_paddr_o;
  logic [127:0] rsp_data_o;

  icache_refill_if #(.PADDR_W(56), .LINE_W(128)) mreq_if ();

  icache_refill #(
    .NUM_SETS(256), .NUM_WAYS(4), .PADDR_W(56), .ICACHE_LINE_WIDTH(128)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_paddr_i(miss_paddr_i), .miss_way_i(miss_way_i),
    .kill_i(kill_i), .flush_i(flush_i), .busy_o(busy_o),
    .mreq(mreq_if),
    .wr_en_o(wr_en_o), .wr_set_o(wr_set_o), .wr_way_o(wr_way_o),
    .wr_tag_o(wr_tag_o), .wr_valid_o(wr_valid_o), .wr_data_o(wr_data_o),
    .rsp_valid_o(rsp_valid_o), .rsp_paddr_o(rsp_paddr_o), .rsp_data_o(rsp_data_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] set; logic [3:0] way; logic [43:0] tag; logic valid; logic [127:0] data; } wr_t;
  typedef struct { int cyc; logic [55:0] paddr; logic [127:0] data; } rs_t;

  wr_t         wq[$];
  rs_t         rq[$];
  int          cyc = 0;
  int          req_lo = 1, req_hi = 0, busy_lo = 1, busy_hi = 0;
  logic [55:0] req_pa = '0;
  int          n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle, DUT outputs against the predicted schedule.
  always @(negedge clk) begin
    wr_t w;
    rs_t r;
    bit  er, eb;
    if (rst_i) begin
      chk("rst_wr_en", 128'(wr_en_o), 128'(0));
      chk("rst_req", 128'(mreq_if.req), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(1));
      chk("rst_miss_ready", 128'(miss_ready_o), 128'(0));
    end else begin
      er = (cyc >= req_lo) && (cyc <= req_hi);
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("req", 128'(mreq_if.req), 128'(er));
      if (er) chk("req_paddr", 128'(mreq_if.paddr), 128'(req_pa));
      chk("busy", 128'(busy_o), 128'(eb));
      chk("miss_ready", 128'(miss_ready_o), 128'(!eb && !flush_i));
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_missing: got no write, expected write set %0h at cyc %0d", wq[0].set, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w = wq.pop_front();
        chk("wr_en", 128'(wr_en_o), 128'(1));
        chk("wr_set", 128'(wr_set_o), 128'(w.set));
        chk("wr_way", 128'(wr_way_o), 128'(w.way));
        chk("wr_valid", 128'(wr_valid_o), 128'(w.valid));
        if (w.valid) begin
          chk("wr_tag", 128'(wr_tag_o), 128'(w.tag));
          chk("wr_data", wr_data_o, w.data);
        end
      end else begin
        chk("wr_en_quiet", 128'(wr_en_o), 128'(0));
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_missing: got no response, expected response %0h at cyc %0d", rq[0].paddr, rq[0].cyc);
        void'(rq.pop_front());
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("rsp_valid", 128'(rsp_valid_o), 128'(1));
        chk("rsp_paddr", 128'(rsp_paddr_o), 128'(r.paddr));
        chk("rsp_data", rsp_data_o, r.data);
      end else begin
        chk("rsp_quiet", 128'(rsp_valid_o), 128'(0));
      end
    end
  end

  task automatic push_flush(input int first);
    for (int k = 0; k < 256; k++)
      wq.push_back('{first + k, 8'(k), 4'hF, 44'h0, 1'b0, 128'h0});
  endtask

  task automatic do_reset_release();
    int r;
    rst_i = 1'b0;
    r = cyc;
    push_flush(r);
    busy_lo = r; busy_hi = r + 255;
    req_lo = 1; req_hi = 0;
    repeat (256) step();
    chk("pin_ready_after_flush", 128'(miss_ready_o), 128'(1));
    chk("pin_idle_after_flush", 128'(busy_o), 128'(0));
  endtask

  // km: 0 none, 1 kill in MEM, 2 kill in FILL, 3 kill in RESP
  // fm: 0 none, 1 flush in MEM, 2 flush in FILL, 3 flush in RESP
  task automatic do_miss(input logic [55:0] a, input int w, input int stall, input int km,
                         input int fm, input logic [31:0] salt, input bit pin);
    int n, idle, kpos, fmode;
    logic [55:0]  la, wa;
    logic [127:0] line;
    bit killed, resp;
    la = a & ~56'hF;
    wa = la >> 2;
    for (int i = 0; i < 4; i++) line[32*i +: 32] = wa[31:0] + 32'(i) + salt;
    killed = (km == 1) || (km == 2);
    fmode  = (killed && fm == 3) ? 0 : fm;
    resp   = !killed && (km != 3);
    kpos   = $urandom_range(stall, 0);
    n      = cyc;
    idle   = n + (killed ? 3 : 4) + stall;
    wq.push_back('{n + 2 + stall, 8'(la >> 4), 4'(1 << w), 44'(la >> 12), 1'b1, line});
    if (resp) rq.push_back('{n + 3 + stall, la, line});
    req_lo = n + 1; req_hi = n + 1 + stall; req_pa = wa;
    busy_lo = n + 1; busy_hi = (fmode != 0) ? idle + 256 : idle - 1;
    if (fmode != 0) push_flush(idle + 1);

    miss_valid_i = 1'b1; miss_paddr_i = a; miss_way_i = 2'(w);
    kill_i = 1'($urandom_range(1, 0)); flush_i = 1'b0;
    step();
    miss_valid_i = 1'b0;
    miss_paddr_i = 56'({$urandom(), $urandom()});
    miss_way_i   = 2'($urandom_range(3, 0));
    for (int i = 0; i <= stall; i++) begin
      mreq_if.ready = (i == stall);
      mreq_if.data  = (i == stall) ? line : {$urandom(), $urandom(), $urandom(), $urandom()};
      kill_i  = (km == 1) && (i == kpos);
      flush_i = (fmode == 1) && (i == 0);
      if (pin && i == 0) chk("pin_mem_paddr", 128'(mreq_if.paddr), 128'h48C);
      step();
    end
    mreq_if.ready = 1'b0;
    mreq_if.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    kill_i  = (km == 2);
    flush_i = (fmode == 2);
    if (pin) begin
      chk("pin_fill_set", 128'(wr_set_o), 128'h23);
      chk("pin_fill_tag", 128'(wr_tag_o), 128'h1);
      chk("pin_fill_way", 128'(wr_way_o), 128'b0100);
      chk("pin_fill_data", wr_data_o, 128'h0000048F_0000048E_0000048D_0000048C);
    end
    step();
    if (!killed) begin
      kill_i  = (km == 3);
      flush_i = (fmode == 3);
      if (pin) begin
        chk("pin_rsp_cycle", 128'(cyc - n), 128'(3));
        chk("pin_rsp_valid", 128'(rsp_valid_o), 128'(1));
        chk("pin_rsp_paddr", 128'(rsp_paddr_o), 128'h1230);
      end
      step();
    end
    kill_i = 1'b0; flush_i = 1'b0;
    if (fmode != 0) while (cyc < idle + 257) step();
  endtask

  task automatic do_flush_idle(input bit with_miss);
    int m;
    m = cyc;
    flush_i = 1'b1; miss_valid_i = with_miss;
    miss_paddr_i = 56'({$urandom(), $urandom()}); kill_i = 1'($urandom_range(1, 0));
    push_flush(m + 1);
    busy_lo = m + 1; busy_hi = m + 256; req_lo = 1; req_hi = 0;
    step();
    flush_i = 1'b0; miss_valid_i = 1'b0; kill_i = 1'b0;
    while (cyc < m + 257) step();
  endtask

  task automatic do_reset_in_mem();
    int n;
    n = cyc;
    miss_valid_i = 1'b1; miss_paddr_i = 56'h00AB_CDEF_0123_45; miss_way_i = 2'd3;
    req_lo = n + 1; req_hi = n + 1; req_pa = 56'h00AB_CDEF_0123_40 >> 2;
    busy_lo = n + 1; busy_hi = n + 1000;
    step();
    miss_valid_i = 1'b0; mreq_if.ready = 1'b0;
    chk("req_before_rst", 128'(mreq_if.req), 128'(1));
    #1;
    rst_i = 1'b1;
    wq.delete(); rq.delete();
    #1;
    chk("rst_drops_req", 128'(mreq_if.req), 128'(0));
    step();
    mreq_if.ready = 1'b1;
    step();
    mreq_if.ready = 1'b0;
    do_reset_release();
  endtask

  initial begin
    int km, fm, r;
    rst_i = 1'b1; miss_valid_i = 1'b0; miss_paddr_i = '0; miss_way_i = '0;
    kill_i = 1'b0; flush_i = 1'b0; mreq_if.ready = 1'b0; mreq_if.data = '0;
    repeat (3) step();
    do_reset_release();
    do_miss(56'h1234, 2, 0, 0, 0, 32'h0, 1'b1);
    do_miss(56'h0012_3456_789A_BC, 1, 5, 0, 0, $urandom(), 1'b0);
    do_miss(56'h0000_0000_0F0F_F7, 0, 2, 1, 0, $urandom(), 1'b0);
    do_miss(56'h00FF_FFFF_FFFF_FF, 3, 0, 3, 0, $urandom(), 1'b0);
    do_miss(56'h0000_0000_0000_08, 2, 1, 0, 1, $urandom(), 1'b0);
    do_flush_idle(1'b1);
    do_reset_in_mem();
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(3, 0)) begin
        kill_i = 1'($urandom_range(1, 0));
        step();
      end
      kill_i = 1'b0;
      if ($urandom_range(9, 0) == 0) begin
        do_flush_idle(1'($urandom_range(1, 0)));
      end else begin
        r  = $urandom_range(7, 0);
        km = (r < 4) ? 0 : r - 4;
        fm = $urandom_range(5, 0);
        if (fm > 3) fm = 0;
        do_miss(56'({$urandom(), $urandom()}), $urandom_range(3, 0), $urandom_range(4, 0),
                km, fm, $urandom(), 1'b0);
      end
    end
    repeat (2) step();
    chk("writes_drained", 128'(wq.size()), 128'(0));
    chk("rsps_drained", 128'(rq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss/refill engine between the icache lookup stage and the line-wide memory port (mem_req_t / mem_rsp_t from ariane_pkg).
- Accepts one miss at a time and issues a line-aligned memory request.
- Captures the ICACHE_LINE_WIDTH-bit line, writes it into the cache tag/data arrays, then returns the line to fetch.
- Also owns whole-cache invalidation: automatically after reset, and on flush_i.

Parameters:
- NUM_SETS, 256, sets in the cache; power of two, >=2.
- NUM_WAYS, 4, ways per set; power of two.
- PADDR_W, 56, physical byte-address width; equals width of mem_req_t.paddr.
- Derived: OFF_W=$clog2(ICACHE_LINE_WIDTH/8), IDX_W=$clog2(NUM_SETS), TAG_W=PADDR_W-IDX_W-OFF_W, WAY_W=$clog2(NUM_WAYS).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- miss_valid_i  in  1  miss request
- miss_ready_o  out  1  miss accepted when valid&&ready
- miss_paddr_i  in  PADDR_W  miss byte address (any alignment)
- miss_way_i  in  WAY_W  victim way chosen by lookup stage
- kill_i  in  1  fetch flush; suppress pending response
- flush_i  in  1  invalidate whole cache (level, sampled per cycle)
- busy_o  out  1  refill or flush in progress/pending
- mreq_o  out  mem_req_t  .req, .paddr (32-bit word address)
- mreq_i  in  mem_rsp_t  .ready, .data[ICACHE_LINE_WIDTH]
- wr_en_o  out  1  array write strobe
- wr_set_o  out  IDX_W  set index written
- wr_way_o  out  NUM_WAYS  one-hot way mask (all-ones during flush)
- wr_tag_o  out  TAG_W  tag written
- wr_valid_o  out  1  valid bit written
- wr_data_o  out  ICACHE_LINE_WIDTH  line written
- rsp_valid_o  out  1  one-cycle response pulse, no backpressure
- rsp_paddr_o  out  PADDR_W  line-aligned address of response
- rsp_data_o  out  ICACHE_LINE_WIDTH  line data

Behaviour:
- States: FLUSH, IDLE, MEM, FILL, RESP. Reset enters FLUSH with set counter=0.
- Reset values:
  - mreq_o.req=0, paddr=0; wr_en_o=0; rsp_valid_o=0; miss_ready_o=0; busy_o=1.
  - Line buffer, latched addr/way, killed_q and flush_pend_q are all 0.
- Reset mid-operation: takes effect immediately (asynchronous), so mreq_o.req drops in the same cycle. Any in-flight refill is discarded and a full flush restarts.
- FLUSH:
  - Each cycle: wr_en_o=1, wr_set_o=counter, wr_way_o=all ones, wr_valid_o=0; counter++.
  - After set NUM_SETS-1 is written (NUM_SETS cycles), go to IDLE and clear flush_pend_q.
- IDLE:
  - miss_ready_o = !flush_i && !flush_pend_q.
  - flush_i (or flush_pend_q) has priority over a simultaneous miss: go to FLUSH, counter=0.
  - On miss accept: latch miss_paddr_i with low OFF_W bits cleared, latch miss_way_i, killed_q=0, go to MEM.
- MEM:
  - mreq_o.req=1, mreq_o.paddr = latched_addr>>2.
  - req and paddr stay stable until mreq_i.ready=1.
  - In the ready cycle, capture mreq_i.data into the line buffer and go to FILL.
- FILL (exactly one cycle):
  - wr_en_o=1, wr_valid_o=1, wr_way_o=1<<way.
  - wr_set_o = addr[OFF_W+:IDX_W], wr_tag_o = addr[PADDR_W-1:OFF_W+IDX_W], wr_data_o = line buffer.
  - The write happens even if killed (the fetched data is correct).
  - Next state: RESP if !killed_q && !kill_i, else IDLE.
- RESP (one cycle):
  - rsp_valid_o = !kill_i; rsp_data_o = line buffer; rsp_paddr_o = latched addr.
  - Then go to IDLE.
- kill_i asserted in MEM or FILL sets killed_q. kill_i has no effect in IDLE or FLUSH.
- flush_i asserted in MEM/FILL/RESP sets flush_pend_q. The refill completes, then FLUSH starts directly after returning to IDLE, with no miss accepted in between.
- busy_o = (state!=IDLE) || flush_pend_q.
- wr_data_o, rsp_* are don't-care when their strobe is low; all strobes are registered-state decodes (no glitch paths from miss_valid_i).
- Miss-to-response latency with ready=1: accept at cycle 0, req at 1, FILL at 2, rsp_valid_o at 3.

Test Plan:
- Reset sequence (NUM_SETS=256, NUM_WAYS=4): release rst_i -> 256 consecutive wr_en_o pulses, sets 0..255, wr_way_o=4'b1111, wr_valid_o=0. Then miss_ready_o=1 and busy_o=0 in cycle 256.
- Miss, LINE=128, memory mem[k]=k, ready=1: miss_paddr_i=0x1234, way=2.
  - mreq_o.paddr=0x48C.
  - FILL: set=0x23, tag=0x1, wr_way_o=4'b0100, data={0x48F,0x48E,0x48D,0x48C}.
  - rsp_valid_o at cycle 3 with rsp_paddr_o=0x1230.
- Memory stall: hold mreq_i.ready=0 for 5 cycles -> req=1 and paddr constant for all 6 MEM cycles; FILL follows the ready cycle; one rsp pulse.
- Kill: kill_i pulse during MEM -> FILL write still occurs, no rsp_valid_o, IDLE after FILL. kill_i during RESP -> rsp_valid_o=0.
- Flush vs miss: flush_i asserted in MEM -> refill writes, rsp pulses, then 256-cycle flush, miss_ready_o=0 throughout. flush_i and miss_valid_i together in IDLE -> flush wins, miss not accepted.
- Async reset in MEM: assert rst_i mid-cycle -> mreq_o.req=0 immediately, no FILL write or response, full flush restarts on release.
